// File: rtl/simon_bus_pkg.sv
// simon_bus_sched shared types and defaults.
// Index width is fixed at 2 bits to match owner/cfg_sel.
package simon_bus_pkg;
  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 8;
  localparam int IDX_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_TURN
  } state_e;
endpackage

// File: rtl/simon_bus_sched_if.sv
// Request/config/bus-control bundle for simon_bus_sched.
// master drives requests and config, slave drives bus control.
import simon_bus_pkg::*;

interface simon_bus_sched_if #(
  parameter int N_REQ = N_REQ_DEF
);
  logic [N_REQ-1:0] req;
  logic             cfg_valid;
  logic [IDX_W-1:0] cfg_sel;
  logic [7:0]       cfg_data;
  logic             cfg_ready;
  logic [N_REQ-1:0] oe;
  logic [N_REQ-1:0] load;
  logic [7:0]       load_data;
  logic [IDX_W-1:0] owner;
  logic             busy;

  modport master (
    output req, cfg_valid, cfg_sel, cfg_data,
    input  cfg_ready, oe, load, load_data,
    input  owner, busy
  );

  modport slave (
    input  req, cfg_valid, cfg_sel, cfg_data,
    output cfg_ready, oe, load, load_data,
    output owner, busy
  );
endinterface

// File: rtl/simon_bus_sched_rr_pick.sv
// Round-robin picker: first set req bit at or after start,
// wrapping at N.
import simon_bus_pkg::*;

module rr_pick #(
  parameter int N = N_REQ_DEF
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] win,
  output logic             found
);
  int               j;
  logic [IDX_W-1:0] k;

  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(start) + i;
      if (j >= N) j = j - N;
      k = IDX_W'(j);
      if (!found && req[k]) begin
        win   = k;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/simon_bus_sched.sv
// Tri-state bus scheduler: round-robin grant with hold limit
// and one-cycle turnaround, plus independent counter loads.
import simon_bus_pkg::*;

module simon_bus_sched #(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic              clk,
  input logic              rst_n,
  simon_bus_sched_if.slave bus
);
  localparam logic [3:0]       HOLD_MAX = 4'(MAX_HOLD);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] oe_q, oe_d;
  logic [N_REQ-1:0] load_q, load_d;
  logic [7:0]       ld_q, ld_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [3:0]       hold_q, hold_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] start, win;
  logic             found, cfg_ready, rel;

  assign start = (last_q == LAST_RST) ? '0 : last_q + 1'b1;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (bus.req),
    .start (start),
    .win   (win),
    .found (found)
  );

  assign cfg_ready = !(state_q == ST_GRANT &&
                       bus.cfg_sel == owner_q);
  assign rel = !bus.req[owner_q] || hold_q == HOLD_MAX;

  always_comb begin
    state_d = state_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_GRANT: begin
        if (rel) begin
          state_d = ST_TURN;
          oe_d    = '0;
          busy_d  = 1'b0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        // IDLE and end-of-TURN arbitrate the same way
        state_d = ST_IDLE;
        oe_d    = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
        if (found) begin
          state_d     = ST_GRANT;
          oe_d[win]   = 1'b1;
          busy_d      = 1'b1;
          owner_d     = win;
          last_d      = win;
          hold_d      = 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    load_d = '0;
    ld_d   = ld_q;
    if (bus.cfg_valid && cfg_ready &&
        int'(bus.cfg_sel) < N_REQ) begin
      load_d[bus.cfg_sel] = 1'b1;
      ld_d                = bus.cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      oe_q    <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      last_q  <= LAST_RST;
      hold_q  <= '0;
      load_q  <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      load_q  <= load_d;
      ld_q    <= ld_d;
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.oe        = oe_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
  assign bus.load      = load_q;
  assign bus.load_data = ld_q;
endmodule

// File: doc/simon_bus_sched.md
SIMON_BUS_SCHED -- requirements
Module: simon_bus_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters/counter instances sharing the tri-state bus.
REQ-002 Parameter MAX_HOLD, default 8, legal 2..15: maximum consecutive cycles one owner may drive the bus.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req  in  N_REQ  per-requester bus request, level, held while bus wanted.
REQ-006 cfg_valid  in  1  configuration-load request.
REQ-007 cfg_sel  in  2  target counter index for configuration load.
REQ-008 cfg_data  in  8  value to parallel-load into the target counter.
REQ-009 cfg_ready  out  1  configuration load accepted this cycle when high with cfg_valid.
REQ-010 oe  out  N_REQ  one-hot-or-zero output enables, one per counter instance.
REQ-011 load  out  N_REQ  one-hot-or-zero registered load strobes, one per counter instance.
REQ-012 load_data  out  8  registered data shared by all counter load_data inputs.
REQ-013 owner  out  2  index of current bus owner; valid only when busy=1.
REQ-014 busy  out  1  high exactly when some oe bit is high.

Function
REQ-015 FSM states IDLE, GRANT, TURN; all outputs registered.
REQ-016 IDLE: if any req bit high, pick winner by round-robin, enter GRANT next cycle with oe[winner]=1; otherwise stay IDLE.
REQ-017 Round-robin: search starts at index (last_owner+1) mod N_REQ, increasing with wrap; last_owner updates at every grant.
REQ-018 Grant latency: req asserted in cycle t while IDLE gives oe high in cycle t+1.
REQ-019 GRANT: hold counter counts cycles in GRANT starting at 1; leave to TURN when req[owner]=0 or count reaches MAX_HOLD, whichever first; both in same cycle leaves exactly once.
REQ-020 TURN: exactly one cycle with oe all zero (bus turnaround, no contention); at end of TURN arbitrate as in IDLE and go to GRANT if any req, else IDLE.
REQ-021 oe SHALL never have more than one bit set in any cycle.
REQ-022 A requester whose req drops then re-rises while owner is released still waits its round-robin turn.
REQ-023 cfg_ready=1 unless state is GRANT and cfg_sel equals owner (no reload of a driving counter).
REQ-024 On cfg_valid and cfg_ready: next cycle load[cfg_sel]=1 for exactly one cycle and load_data=cfg_data; load_data holds its value afterwards.
REQ-025 cfg_sel values >= N_REQ SHALL be ignored (no load pulse), cfg_ready still 1.
REQ-026 Config loads and bus arbitration proceed independently in the same cycle.

Reset
REQ-027 While rst_n=0 at a clock edge: state IDLE, oe=0, load=0, load_data=0, owner=0, busy=0, hold counter=0, last_owner=N_REQ-1 (requester 0 first priority).
REQ-028 Reset asserted mid-GRANT drops oe to 0 at that edge; no TURN cycle is required afterward.
REQ-029 cfg_ready combinational from registered state; equals 1 during and immediately after reset.

Structure
REQ-030 Package simon_bus_pkg holds the FSM state enum, N_REQ default and MAX_HOLD default.
REQ-031 One combinational sub-module rr_pick (request vector, start index -> winner index, found flag).
REQ-032 Hold counter 4 bits; no other arithmetic wider than needed.

Verification
REQ-033 req=0001 from reset -> oe=0001 next cycle, busy=1, owner=0; drop req -> one TURN cycle oe=0000, then IDLE.
REQ-034 req=1111 held -> grants 0,1,2,3,0 each 8 cycles of oe separated by single zero cycles.
REQ-035 req=0101 held, MAX_HOLD=8 -> owner alternates 0,2,0; req[0] dropped at hold count 8 -> single TURN.
REQ-036 owner=2 in GRANT, cfg_valid cfg_sel=2 -> cfg_ready=0, no load; cfg_sel=1 data 0xA5 -> load=0010, load_data=0xA5 one cycle later.
REQ-037 rst_n low during GRANT -> oe=0000, load=0000 next edge; after release req=1000 -> requester 3 granted, owner=3.
REQ-038 Every cycle of all scenarios: assert oe one-hot-or-zero and busy equals OR of oe.
